// File: rtl/receptor_serial_pkg.sv
// Shared definitions for the serial receiver: FSM state codes, frame constants
// and the idle line level.
package receptor_serial_pkg;

  typedef logic [2:0] estado_rx_t;

  localparam estado_rx_t OCIOSO       = 3'd0;
  localparam estado_rx_t INICIO       = 3'd1;
  localparam estado_rx_t DADOS        = 3'd2;
  localparam estado_rx_t PARIDADE     = 3'd3;
  localparam estado_rx_t PARADA       = 3'd4;
  localparam estado_rx_t ESPERA_LINHA = 3'd5;

  localparam int   BITS_DADO    = 8;
  localparam int   BITS_QUADRO  = 11;
  localparam logic NIVEL_OCIOSO = 1'b1;

  // Odd number of ones across data plus parity means an even-parity violation.
  function automatic logic paridade_impar(input logic [BITS_DADO:0] quadro);
    return ^quadro;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level.
module sincronizador_2ff
  import receptor_serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= NIVEL_OCIOSO;
      q       <= NIVEL_OCIOSO;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/receptor_serial.sv
// 8E1-style serial receiver: start, 8 data bits LSB first, even parity, stop.
// Define RECEPTOR_PARIDADE_EN to add the erro_paridade output.
module receptor_serial
  import receptor_serial_pkg::*;
#(
  parameter int CLKS_POR_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [BITS_DADO:0]   dado,
  output logic                 valido,
`ifdef RECEPTOR_PARIDADE_EN
  output logic                 erro_paridade,
`endif
  output logic                 erro_quadro
);

  localparam int                CNT_W    = $clog2(CLKS_POR_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_POR_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MEIO = CNT_W'(CLKS_POR_BIT / 2 - 1);
  localparam logic [2:0]        IDX_FIM  = 3'(BITS_DADO - 1);

  logic                 rx_s;
  estado_rx_t           estado;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [BITS_DADO-1:0] sr;
  logic                 par_bit;

  sincronizador_2ff u_sinc (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= OCIOSO;
      cnt           <= '0;
      idx           <= '0;
      dado          <= '0;
      valido        <= 1'b0;
      erro_quadro   <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
      erro_paridade <= 1'b0;
`endif
    end else begin
      valido        <= 1'b0;
      erro_quadro   <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
      erro_paridade <= 1'b0;
`endif
      case (estado)
        OCIOSO: begin
          cnt <= '0;
          if (!rx_s) begin
            estado <= INICIO;
            idx    <= '0;
          end
        end
        // Half a bit in, a high line means the falling edge was only a glitch.
        INICIO: begin
          if (cnt == CNT_MEIO) begin
            cnt    <= '0;
            estado <= rx_s ? OCIOSO : DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DADOS: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            sr  <= {rx_s, sr[BITS_DADO-1:1]};
            idx <= idx + 3'd1;
            if (idx == IDX_FIM) estado <= PARIDADE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            par_bit <= rx_s;
            estado  <= PARADA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A low stop bit leaves dado untouched and waits for the line to idle.
        PARADA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (rx_s) begin
              dado   <= {par_bit, sr};
              valido <= 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
              erro_paridade <= paridade_impar({par_bit, sr});
`endif
              estado <= OCIOSO;
            end else begin
              erro_quadro <= 1'b1;
              estado      <= ESPERA_LINHA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ESPERA_LINHA: begin
          cnt <= '0;
          if (rx_s) estado <= OCIOSO;
        end
        default: begin
          cnt    <= '0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
